// File: rtl/twiddle_ram_loader_pkg.sv
// twiddle_ram_loader_pkg: shared FFT types: loader state enum, error codes, Q1.15 component width
package twiddle_ram_loader_pkg;
  localparam int Q_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, LOAD, READY, ERR} state_t;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CFG     = 2'd1;
  localparam logic [1:0] ERR_EARLY   = 2'd2;
  localparam logic [1:0] ERR_MISSING = 2'd3;
endpackage

// File: rtl/twiddle_dpram.sv
// twiddle_dpram: simple dual-port twiddle table, one sync write port and one registered read port
// i_we/i_waddr/i_wdr/i_wdi: write strobe, index, real/imag data
// i_re/i_raddr: read strobe and index; o_rdr/o_rdi: registered read data
module twiddle_dpram #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdr,
  input  logic [WIDTH-1:0]      i_wdi,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdr,
  output logic [WIDTH-1:0]      o_rdi
);
  logic [WIDTH-1:0] r_mem_r [2**ADDR_WIDTH];
  logic [WIDTH-1:0] r_mem_i [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem_r[i_waddr] <= i_wdr;
      r_mem_i[i_waddr] <= i_wdi;
    end
    if (i_re) begin
      o_rdr <= r_mem_r[i_raddr];
      o_rdi <= r_mem_i[i_raddr];
    end
  end
endmodule

// File: rtl/twiddle_ram_loader.sv
// twiddle_ram_loader: streams N/2 Q1.15 twiddle pairs into a table and serves gated 1-cycle reads
// cfg_log2n/start: launch a load of E = 2^(cfg_log2n-1) pairs
// s_valid/s_ready/s_wr/s_wi/s_last: input pair stream
// rd_en/rd_addr -> rd_valid/rd_wr/rd_wi: table read, zero when not valid
// busy/table_valid/err/err_code: load status
module twiddle_ram_loader
  import twiddle_ram_loader_pkg::*;
#(
  parameter int WIDTH      = Q_WIDTH,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cfg_log2n,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_wr,
  input  logic [WIDTH-1:0]      s_wi,
  input  logic                  s_last,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_wr,
  output logic [WIDTH-1:0]      rd_wi,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  table_valid,
  output logic                  err,
  output logic [1:0]            err_code
);
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_last;
  logic [1:0]            r_err_code;
  logic                  r_rd_valid;
  logic [WIDTH-1:0]      w_q_r;
  logic [WIDTH-1:0]      w_q_i;
  logic                  w_cfg_ok;
  logic                  w_fire;
  logic                  w_at_end;
  logic                  w_rd_ok;
  // r_last holds E-1, so the in-range read test is rd_addr <= r_last
  assign w_cfg_ok = cfg_log2n >= 4'd2 && cfg_log2n <= 4'(ADDR_WIDTH + 1);
  assign w_fire   = r_state == LOAD && s_valid;
  assign w_at_end = r_wr_ptr == r_last;
  assign w_rd_ok  = rd_en && r_state == READY && rd_addr <= r_last;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_last     <= '0;
      r_err_code <= ERR_NONE;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      case (r_state)
        LOAD: if (s_valid) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (s_last && !w_at_end) begin
            r_state    <= ERR;
            r_err_code <= ERR_EARLY;
          end else if (w_at_end && !s_last) begin
            r_state    <= ERR;
            r_err_code <= ERR_MISSING;
          end else if (w_at_end) r_state <= READY;
        end
        default: if (start) begin
          r_last     <= ADDR_WIDTH'((1 << (cfg_log2n - 4'd1)) - 1);
          r_wr_ptr   <= '0;
          r_err_code <= w_cfg_ok ? ERR_NONE : ERR_CFG;
          r_state    <= w_cfg_ok ? LOAD : ERR;
        end
      endcase
    end
  end
  twiddle_dpram #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk    (clk),
    .i_we   (w_fire),
    .i_waddr(r_wr_ptr),
    .i_wdr  (s_wr),
    .i_wdi  (s_wi),
    .i_re   (w_rd_ok),
    .i_raddr(rd_addr),
    .o_rdr  (w_q_r),
    .o_rdi  (w_q_i)
  );
  assign s_ready     = r_state == LOAD;
  assign busy        = r_state == LOAD;
  assign table_valid = r_state == READY;
  assign err         = r_state == ERR;
  assign err_code    = r_err_code;
  assign rd_valid    = r_rd_valid;
  assign rd_wr       = r_rd_valid ? w_q_r : '0;
  assign rd_wi       = r_rd_valid ? w_q_i : '0;
endmodule
